// File: rtl/sub_seq_pkg.sv
// Shared definitions for the bit-serial prefix subtractor: default width,
// FSM state encoding and the step-counter sizing helper.
package sub_seq_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PREFIX = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Counter width for WIDTH steps; kept at least 1 bit so the vector is legal.
    function automatic int step_bits(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/gp_merge.sv
// Single-bit prefix cell: carry out from generate/propagate and incoming carry.
module gp_merge (
    input  logic g_i,
    input  logic p_i,
    input  logic c_i,
    output logic c_o
);

    assign c_o = g_i | (p_i & c_i);

endmodule

// File: rtl/sub_8b_seq.sv
// Sequential subtractor: a - b as a + ~b + 1, resolving one carry per cycle
// through a reused prefix cell, with valid/ready handshakes on both sides.
module sub_8b_seq
    import sub_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int KW = step_bits(WIDTH);
    localparam logic [KW-1:0] K_LAST = KW'(WIDTH - 1);
    localparam logic [KW-1:0] K_ONE  = KW'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] g_q, g_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [KW-1:0]    k_prev;
    logic             c_in;
    logic             c_out;

    // Carry-in of the subtraction (the +1) enters as C[-1] on the first step.
    assign k_prev = k_q - K_ONE;
    assign c_in   = (k_q == '0) ? 1'b1 : c_q[k_prev];

    gp_merge u_gp_merge (
        .g_i (g_q[k_q]),
        .p_i (p_q[k_q]),
        .c_i (c_in),
        .c_o (c_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            g_q     <= '0;
            p_q     <= '0;
            c_q     <= '0;
            k_q     <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            p_q     <= p_d;
            c_q     <= c_d;
            k_q     <= k_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        p_d     = p_q;
        c_d     = c_q;
        k_d     = k_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    g_d     = a & ~b;
                    p_d     = a ^ ~b;
                    c_d     = '0;
                    k_d     = '0;
                    state_d = PREFIX;
                end
            end
            PREFIX: begin
                c_d[k_q] = c_out;
                k_d      = k_q + K_ONE;
                // Last step: the full carry vector is known, so the result
                // is formed here and registered together with the DONE entry.
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    diff_d  = p_q ^ {c_d[WIDTH-2:0], 1'b1};
                    bout_d  = ~c_d[WIDTH-1];
                    ovf_d   = c_d[WIDTH-1] ^ c_d[WIDTH-2];
                    zero_d  = (diff_d == '0);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: doc/sub_8b_seq.md
SUB_8B_SEQ -- requirements
Module: sub_8b_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width; the prefix step count equals WIDTH.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, operand pair a/b present.
REQ-005 SHALL have port in_ready, output, 1, block can accept operands.
REQ-006 SHALL have port a, input, WIDTH, minuend, unsigned or two's complement.
REQ-007 SHALL have port b, input, WIDTH, subtrahend.
REQ-008 SHALL have port out_valid, output, 1, result present.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-010 SHALL have port diff, output, WIDTH, a minus b modulo 2^WIDTH.
REQ-011 SHALL have port bout, output, 1, borrow out: 1 when unsigned a < b.
REQ-012 SHALL have port ovf, output, 1, signed overflow of a minus b.
REQ-013 SHALL have port zero, output, 1, 1 when diff equals 0.

Function
REQ-014 SHALL compute a + ~b + 1: per bit g_i = a_i & ~b_i, p_i = a_i ^ ~b_i, carry-in fixed 1.
REQ-015 SHALL use a three-state FSM: IDLE, PREFIX, DONE.
REQ-016 SHALL assert in_ready only in IDLE; an input handshake (in_valid & in_ready) registers g, p, clears step index k to 0, and enters PREFIX.
REQ-017 SHALL, in PREFIX, resolve one serial-prefix level per cycle: C[k] = g_k | (p_k & C[k-1]), with C[-1] = 1, then increment k.
REQ-018 SHALL enter DONE on the edge that resolves k = WIDTH-1, so out_valid rises exactly WIDTH cycles after the accepting edge (8 for WIDTH=8).
REQ-019 SHALL form diff_i = p_i ^ C[i-1], bout = ~C[WIDTH-1], ovf = C[WIDTH-1] ^ C[WIDTH-2], and zero = (diff == 0), all registered and valid with out_valid.
REQ-020 SHALL hold diff, bout, ovf, zero and out_valid stable while out_valid = 1 and out_ready = 0, for any number of cycles.
REQ-021 SHALL return to IDLE on an output handshake (out_valid & out_ready); out_valid drops the following cycle; the next input is accepted no earlier than the cycle after return to IDLE.
REQ-022 SHALL ignore a, b and in_valid outside IDLE; operands changing mid-operation do not affect the result.
REQ-023 SHALL ignore out_ready outside DONE.

Reset
REQ-024 SHALL, on rst_n low, asynchronously enter IDLE with in_ready = 1 after release, out_valid = 0, diff = 0, bout = 0, ovf = 0, zero = 0, k = 0.
REQ-025 SHALL abort any operation in PREFIX or DONE when reset asserts; no partial result is ever presented afterwards.

Structure
REQ-026 SHALL take WIDTH default and the state enum (IDLE, PREFIX, DONE) from a shared package sub_seq_pkg.
REQ-027 SHALL instantiate one sub-module, gp_merge, the single-bit prefix cell C_out = g | (p & C_in), reused for each PREFIX step.
REQ-028 SHALL hold datapath state in one g register, one p register, one WIDTH-bit carry vector, and a step counter of ceil(log2(WIDTH)) bits.

Verification
REQ-029 SHALL check a=0x05, b=0x03 -> diff=0x02, bout=0, ovf=0, zero=0, with out_valid 8 cycles after the accept edge.
REQ-030 SHALL check a=0x03, b=0x05 -> diff=0xFE, bout=1, ovf=0, zero=0.
REQ-031 SHALL check a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1; and a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
REQ-032 SHALL check a=0x00, b=0x00 -> diff=0x00, zero=1, bout=0.
REQ-033 SHALL hold out_ready=0 for 5 cycles after out_valid -> outputs constant, in_ready=0 throughout, and in_valid pulses with new operands are ignored.
REQ-034 SHALL pull rst_n low at PREFIX step 4 -> out_valid=0 and all outputs 0 immediately, then a fresh 0x10-0x01 completes with diff=0x0F.
